csa_accum: RTL and testbench

//  Streaming carry-save accumulator for the multiply/MAC datapath.

---
 rtl/csa_accum.sv | 62 ++++++
 tb/tb_csa_accum.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/csa_accum.sv
// csa_accum: streaming carry-save accumulator with a single carry-propagate resolve per batch
module csa_accum #(
  parameter int IN_WIDTH  = 64,
  parameter int ACC_WIDTH = 72,
  parameter int SIGNED    = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_sub,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count
);
  typedef enum logic [1:0] {ACC, RESOLVE, HOLD} state_t;
  state_t state, state_n;
  logic [ACC_WIDTH-1:0] s, c, x, maj;
  logic [CNT_W-1:0] cnt;
  logic take, done;
  assign in_ready = state == ACC;
  assign take = in_valid && in_ready;
  assign done = out_valid && out_ready;
  assign x = {{(ACC_WIDTH-IN_WIDTH){SIGNED != 0 && in_data[IN_WIDTH-1]}}, in_data} ^ {ACC_WIDTH{in_sub}};
  assign maj = (s & c) | (s & x) | (c & x);
  always_comb
    state_n = state == ACC ? (take && in_last ? RESOLVE : ACC) :
              state == RESOLVE ? HOLD : (done ? ACC : HOLD);
  always_ff @(posedge clk)
    if (rst) state <= ACC;
    else state <= state_n;
  // out_valid rises one cycle into HOLD, giving a two-edge latency from the last beat
  always_ff @(posedge clk)
    if (rst) begin
      s <= '0;
      c <= '0;
      cnt <= '0;
      out_sum <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (take) begin
        s <= s ^ c ^ x;
        c <= {maj[ACC_WIDTH-2:0], in_sub};
        cnt <= cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
      end
      if (state == RESOLVE) begin
        out_sum <= s + c;
        out_count <= cnt;
      end
      if (state == HOLD) out_valid <= !done;
      if (done) begin
        s <= '0;
        c <= '0;
        cnt <= '0;
      end
    end
endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: random and directed checks of csa_accum against an arithmetic running-sum model
module tb_csa_accum;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_sub = 0, in_last = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic in_ready, in_ready_u, in_ready_c;
  logic out_valid, out_valid_u, out_valid_c;
  logic [71:0] out_sum, out_sum_u, out_sum_c;
  logic [7:0] out_count, out_count_u;
  logic [1:0] out_count_c;
  int checks = 0, fails = 0;
  logic [71:0] ms, mu;
  int mc;

  always #5 clk = ~clk;

  csa_accum dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count));
  csa_accum #(.SIGNED(0)) dut_u (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_sum(out_sum_u), .out_count(out_count_u));
  csa_accum #(.CNT_W(2)) dut_c (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_sum(out_sum_c), .out_count(out_count_c));

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    ms = '0;
    mu = '0;
    mc = 0;
  endtask

  task automatic beat(input logic [63:0] d, input logic sub, input logic last);
    logic signed [71:0] sx;
    logic [71:0] zx;
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_in_ready", {71'd0, in_ready}, 72'd1);
    in_valid = 1;
    in_data = d;
    in_sub = sub;
    in_last = last;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
    sx = $signed(d);
    zx = {8'd0, d};
    ms = sub ? ms - sx : ms + sx;
    mu = sub ? mu - zx : mu + zx;
    mc++;
  endtask

  // called just after the edge that accepted the last beat
  task automatic finish_batch(input int hold, input logic junk);
    logic [71:0] held;
    @(posedge clk);
    #1;
    check("resolve_in_ready", {71'd0, in_ready}, 72'd0);
    @(posedge clk);
    #1;
    check("out_valid", {71'd0, out_valid}, 72'd1);
    check("out_sum_s", out_sum, ms);
    check("out_sum_u", out_sum_u, mu);
    check("out_count", {64'd0, out_count}, 72'(mc > 255 ? 255 : mc));
    check("out_count_sat", {70'd0, out_count_c}, 72'(mc > 3 ? 3 : mc));
    check("out_sum_c", out_sum_c, ms);
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        in_valid = 1;
        in_data = {$urandom, $urandom};
        in_sub = 1'($urandom);
        in_last = 1'($urandom);
      end
      @(posedge clk);
      #1;
      check("hold_valid", {71'd0, out_valid}, 72'd1);
      check("hold_sum", out_sum, held);
      check("hold_in_ready", {71'd0, in_ready}, 72'd0);
    end
    in_valid = 0;
    in_last = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    check("post_hs_valid", {71'd0, out_valid}, 72'd0);
    check("post_hs_in_ready", {71'd0, in_ready}, 72'd1);
    clear_model();
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_valid", {71'd0, out_valid}, 72'd0);
    check("rst_in_ready", {71'd0, in_ready}, 72'd1);
    check("rst_sum", out_sum, 72'd0);
    check("rst_count", {64'd0, out_count}, 72'd0);

    beat(64'd3, 0, 0);
    beat(64'd5, 0, 0);
    beat(64'd7, 0, 1);
    finish_batch(0, 0);
    check("t1_sum", out_sum, 72'd15);

    beat(64'd10, 0, 0);
    beat(64'd3, 1, 0);
    beat(64'd20, 1, 1);
    finish_batch(0, 0);
    check("t2_sum", out_sum, 72'hFF_FFFF_FFFF_FFFF_FFF3);

    beat(64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    finish_batch(0, 0);
    check("t3_sum_s", out_sum, 72'hFF_FFFF_FFFF_FFFF_FFFE);
    check("t3_sum_u", out_sum_u, 72'h01_FFFF_FFFF_FFFF_FFFE);

    beat(64'd9, 0, 0);
    beat(64'd11, 0, 1);
    finish_batch(5, 1);
    check("t4_sum", out_sum, 72'd20);

    beat(64'd42, 0, 1);
    finish_batch(0, 0);
    check("t5_sum", out_sum, 72'd42);
    check("t5_count", {64'd0, out_count}, 72'd1);
    for (int i = 0; i < 5; i++) beat(64'd1, 0, i == 4);
    finish_batch(0, 0);
    check("t5_sat_sum", out_sum_c, 72'd5);
    check("t5_sat_count", {70'd0, out_count_c}, 72'd3);

    beat(64'd100, 0, 0);
    beat(64'd100, 0, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    clear_model();
    check("t6_rst_sum", out_sum, 72'd0);
    check("t6_rst_valid", {71'd0, out_valid}, 72'd0);
    beat(64'd1, 0, 1);
    finish_batch(0, 0);
    check("t6_sum", out_sum, 72'd1);
    check("t6_count", {64'd0, out_count}, 72'd1);

    for (int b = 0; b < 12; b++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [63:0] d;
        d = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : {$urandom, $urandom};
        beat(d, 1'($urandom), i == n - 1);
      end
      finish_batch($urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
